// File: rtl/lane_stage_reg_if.sv
// rtl/lane_stage_reg_if.sv - upstream/downstream group handshake bundle for lane_stage_reg
interface lane_stage_reg_if #(
  parameter int LANES = 2,
  parameter int DW    = 104,
  parameter int SW    = 150
);
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES-1:0]      in_lane_en;
  logic [LANES*DW-1:0]   in_data;
  logic [SW-1:0]         in_side;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES-1:0]      out_lane_en;
  logic [LANES*DW-1:0]   out_data;
  logic [SW-1:0]         out_side;

  modport master (
    output in_valid, in_lane_en, in_data, in_side, out_ready,
    input  in_ready, out_valid, out_lane_en, out_data, out_side
  );

  modport slave (
    input  in_valid, in_lane_en, in_data, in_side, out_ready,
    output in_ready, out_valid, out_lane_en, out_data, out_side
  );
endinterface

// File: rtl/lane_stage_reg.sv
// rtl/lane_stage_reg.sv - elastic multi-lane stage register, skid entry enabled by LANE_STAGE_SKID_EN
module lane_stage_reg #(
  parameter int LANES = 2,
  parameter int DW    = 104,
  parameter int SW    = 150,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             flush_cause_i,
  lane_stage_reg_if.slave  bus,
  output logic [1:0]       occupancy_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  logic [LANES-1:0]    main_en_q, main_en_d;
  logic [LANES*DW-1:0] main_data_q, main_data_d;
  logic [SW-1:0]       main_side_q, main_side_d;
  logic [LANES*DW-1:0] in_data_m;
  logic [CNT_W-1:0]    bubble_q, bubble_d;
  logic                main_vld, push, pop, xflush, in_ready;

  // Disabled lanes are zeroed on entry so the stored group already obeys the NOP convention.
  always_comb begin
    in_data_m = '0;
    for (int i = 0; i < LANES; i++) begin
      in_data_m[i*DW +: DW] = bus.in_lane_en[i] ? bus.in_data[i*DW +: DW] : '0;
    end
  end

  // An entry is occupied exactly when at least one of its lanes is enabled.
  assign main_vld = |main_en_q;
  assign xflush   = flush_i & flush_cause_i;
  assign push     = bus.in_valid & in_ready & (|bus.in_lane_en);
  assign pop      = main_vld & bus.out_ready;

`ifdef LANE_STAGE_SKID_EN
  logic [LANES-1:0]    skid_en_q, skid_en_d;
  logic [LANES*DW-1:0] skid_data_q, skid_data_d;
  logic [SW-1:0]       skid_side_q, skid_side_d;
  logic                skid_vld, in_ready_q, in_ready_d;

  assign skid_vld = |skid_en_q;

  always_comb begin
    main_en_d   = main_en_q;
    main_data_d = main_data_q;
    main_side_d = main_side_q;
    skid_en_d   = skid_en_q;
    skid_data_d = skid_data_q;
    skid_side_d = skid_side_q;
    if (xflush) begin
      main_en_d   = '0;
      main_data_d = '0;
      main_side_d = '0;
      skid_en_d   = '0;
      skid_data_d = '0;
      skid_side_d = '0;
    end else begin
      if (pop) begin
        main_en_d   = skid_en_q;
        main_data_d = skid_data_q;
        main_side_d = skid_side_q;
        skid_en_d   = '0;
        skid_data_d = '0;
        skid_side_d = '0;
      end
      if (push) begin
        if (!main_vld || (pop && !skid_vld)) begin
          main_en_d   = bus.in_lane_en;
          main_data_d = in_data_m;
          main_side_d = bus.in_side;
        end else begin
          skid_en_d   = bus.in_lane_en;
          skid_data_d = in_data_m;
          skid_side_d = bus.in_side;
        end
      end
    end
    in_ready_d = ~((|main_en_d) & (|skid_en_d));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_en_q   <= '0;
      skid_data_q <= '0;
      skid_side_q <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      skid_en_q   <= skid_en_d;
      skid_data_q <= skid_data_d;
      skid_side_q <= skid_side_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign occupancy_o = {1'b0, main_vld} + {1'b0, skid_vld};
`else
  always_comb begin
    main_en_d   = main_en_q;
    main_data_d = main_data_q;
    main_side_d = main_side_q;
    if (xflush || (pop && !push)) begin
      main_en_d   = '0;
      main_data_d = '0;
      main_side_d = '0;
    end else if (push) begin
      main_en_d   = bus.in_lane_en;
      main_data_d = in_data_m;
      main_side_d = bus.in_side;
    end
  end

  assign in_ready    = bus.out_ready | ~main_vld;
  assign occupancy_o = {1'b0, main_vld};
`endif

  assign bubble_d = (!main_vld && !(&bubble_q)) ? bubble_q + {{(CNT_W-1){1'b0}}, 1'b1} : bubble_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_en_q   <= '0;
      main_data_q <= '0;
      main_side_q <= '0;
      bubble_q    <= '0;
    end else begin
      main_en_q   <= main_en_d;
      main_data_q <= main_data_d;
      main_side_q <= main_side_d;
      bubble_q    <= bubble_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = main_vld;
  assign bus.out_lane_en = main_en_q;
  assign bus.out_data    = main_data_q;
  assign bus.out_side    = main_side_q;
  assign bubble_cnt_o    = bubble_q;

endmodule

// File: tb/tb_lane_stage_reg.sv
// tb/tb_lane_stage_reg.sv - scoreboard bench for lane_stage_reg (either LANE_STAGE_SKID_EN build)
module tb_lane_stage_reg;
  localparam int LANES = 2;
  localparam int DW    = 16;
  localparam int SW    = 8;
  localparam int GW    = LANES + LANES*DW + SW;
`ifdef LANE_STAGE_SKID_EN
  localparam logic [1:0] FULL = 2'd2;
`else
  localparam logic [1:0] FULL = 2'd1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        flush_cause = 1'b0;
  logic [1:0]  occ, occ2;
  logic [15:0] bub;
  logic [3:0]  bub2;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [GW-1:0] sb[$];

  lane_stage_reg_if #(.LANES(LANES), .DW(DW), .SW(SW)) bif ();
  lane_stage_reg_if #(.LANES(LANES), .DW(DW), .SW(SW)) bif2 ();

  lane_stage_reg #(.LANES(LANES), .DW(DW), .SW(SW), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush_i(flush), .flush_cause_i(flush_cause),
    .bus(bif), .occupancy_o(occ), .bubble_cnt_o(bub)
  );

  lane_stage_reg #(.LANES(LANES), .DW(DW), .SW(SW), .CNT_W(4)) dut_cnt4 (
    .clk(clk), .rst(rst), .flush_i(1'b0), .flush_cause_i(1'b0),
    .bus(bif2), .occupancy_o(occ2), .bubble_cnt_o(bub2)
  );

  always #5 clk = ~clk;

  initial begin
    bif2.in_valid = 1'b0; bif2.in_lane_en = '0; bif2.in_data = '0;
    bif2.in_side = '0; bif2.out_ready = 1'b1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mask(input logic [1:0] en, input logic [31:0] d);
    return {en[1] ? d[31:16] : 16'h0, en[0] ? d[15:0] : 16'h0};
  endfunction

  task automatic drive(input logic v, input logic [1:0] en, input logic [31:0] d,
                       input logic [7:0] s, input logic fl, input logic fc, output logic acc);
    bif.in_valid = v; bif.in_lane_en = en; bif.in_data = d; bif.in_side = s;
    flush = fl; flush_cause = fc;
    #1;
    acc = v & bif.in_ready & (|en) & ~(fl & fc);
    if (fl & fc) sb.delete();
    else if (acc) sb.push_back({en, mask(en, d), s});
  endtask

  task automatic idle();
    logic a;
    drive(1'b0, 2'b00, 32'h0, 8'h0, 1'b0, 1'b0, a);
  endtask

  task automatic send_wait(input logic [1:0] en, input logic [31:0] d, input logic [7:0] s);
    logic a;
    int n;
    a = 1'b0;
    n = 0;
    while (!a && n < 10) begin
      drive(1'b1, en, d, s, 1'b0, 1'b0, a);
      n++;
      @(negedge clk);
    end
    chk("send_wait_accepted", a, 1'b1);
  endtask

  // Monitor: every consumed group must match the scoreboard head; idle output must be all zero.
  initial begin
    logic [GW-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (bif.out_valid) begin
        if (bif.out_ready) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL out_unexpected: got %0h expected none at %0t",
                     {bif.out_lane_en, bif.out_data, bif.out_side}, $time);
          end else begin
            e = sb.pop_front();
            chk("out_group", {bif.out_lane_en, bif.out_data, bif.out_side}, e);
          end
        end
      end else begin
        chk("bubble_zero", {bif.out_lane_en, bif.out_data, bif.out_side}, '0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc;
    logic [15:0] hi, lo;
    logic [31:0] held;
    idle();
    bif.out_ready = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_out_valid", bif.out_valid, 1'b0);
    chk("rst_occ", occ, 2'd0);
    chk("rst_bub", bub, 16'd0);
    chk("rst_in_ready", bif.in_ready, 1'b1);
    chk("rst_bub2", bub2, 4'd0);

    // Streaming: 8 back-to-back groups, released from reset on the first push.
    rst = 1'b0;
    bif.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      hi = 16'hA000 + 16'(i);
      lo = 16'h5000 + 16'(i);
      drive(1'b1, 2'b11, {hi, lo}, 8'(i * 3 + 1), 1'b0, 1'b0, acc);
      chk("stream_acc", acc, 1'b1);
      @(negedge clk);
    end
    idle();
    @(negedge clk);
    chk("stream_bub", bub, 16'd1);
    chk("stream_end_valid", bif.out_valid, 1'b0);
    chk("stream_drained", 32'(sb.size()), 32'd0);
    chk("cnt4_bub_9", bub2, 4'd9);

    // Lane masking and empty-lane groups.
    drive(1'b1, 2'b10, 32'hBEEF_DEAD, 8'h5A, 1'b0, 1'b0, acc);
    @(negedge clk);
    chk("mask_en", bif.out_lane_en, 2'b10);
    chk("mask_lane0", bif.out_data[15:0], 16'h0000);
    chk("mask_lane1", bif.out_data[31:16], 16'hBEEF);
    drive(1'b1, 2'b00, 32'h1234_5678, 8'hFF, 1'b0, 1'b0, acc);
    chk("empty_en_acc", acc, 1'b0);
    @(negedge clk);
    idle();
    chk("empty_en_valid", bif.out_valid, 1'b0);
    chk("empty_en_occ", occ, 2'd0);

    // Backpressure.
    bif.out_ready = 1'b0;
    drive(1'b1, 2'b11, 32'hAAAA_0001, 8'hA1, 1'b0, 1'b0, acc);
    chk("bp_acc_a", acc, 1'b1);
    @(negedge clk);
    chk("bp_occ_a", occ, 2'd1);
`ifdef LANE_STAGE_SKID_EN
    chk("bp_rdy_a", bif.in_ready, 1'b1);
    drive(1'b1, 2'b11, 32'hBBBB_0002, 8'hB2, 1'b0, 1'b0, acc);
    chk("bp_acc_b", acc, 1'b1);
    @(negedge clk);
    chk("bp_occ_b", occ, 2'd2);
    chk("bp_rdy_b", bif.in_ready, 1'b0);
    held = 32'hCCCC_0003;
`else
    chk("bp_rdy_a", bif.in_ready, 1'b0);
    held = 32'hBBBB_0002;
`endif
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 2'b11, held, 8'hC3, 1'b0, 1'b0, acc);
      chk("bp_hold_acc", acc, 1'b0);
      chk("bp_hold_head", bif.out_data, 32'hAAAA_0001);
      @(negedge clk);
    end
    bif.out_ready = 1'b1;
    send_wait(2'b11, held, 8'hC3);
    idle();
    repeat (4) @(negedge clk);
    chk("bp_drained", 32'(sb.size()), 32'd0);
    chk("bp_end_valid", bif.out_valid, 1'b0);

    // Exception flush from a full stage drops contents and the same-cycle push.
    bif.out_ready = 1'b0;
    drive(1'b1, 2'b11, 32'h1111_0001, 8'h11, 1'b0, 1'b0, acc);
    @(negedge clk);
`ifdef LANE_STAGE_SKID_EN
    drive(1'b1, 2'b01, 32'h2222_0002, 8'h22, 1'b0, 1'b0, acc);
    @(negedge clk);
`endif
    chk("fl_occ_pre", occ, FULL);
    drive(1'b1, 2'b11, 32'hDDDD_0004, 8'hD4, 1'b1, 1'b1, acc);
    @(negedge clk);
    idle();
    chk("fl_valid", bif.out_valid, 1'b0);
    chk("fl_occ", occ, 2'd0);
    chk("fl_rdy", bif.in_ready, 1'b1);
    drive(1'b1, 2'b11, 32'hDDDD_0004, 8'hD4, 1'b1, 1'b1, acc);
    chk("fl_empty_rdy", bif.in_ready, 1'b1);
    @(negedge clk);
    idle();
    chk("fl_empty_valid", bif.out_valid, 1'b0);
    drive(1'b1, 2'b11, 32'hDDDD_0004, 8'hD4, 1'b1, 1'b0, acc);
    chk("nfl_acc", acc, 1'b1);
    @(negedge clk);
    idle();
    chk("nfl_valid", bif.out_valid, 1'b1);
    chk("nfl_occ", occ, 2'd1);
    chk("nfl_data", bif.out_data, 32'hDDDD_0004);
    bif.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("nfl_drained", 32'(sb.size()), 32'd0);
    chk("cnt4_sat", bub2, 4'd15);

    // Asynchronous reset while holding data.
    bif.out_ready = 1'b0;
    drive(1'b1, 2'b11, 32'h3333_0005, 8'h35, 1'b0, 1'b0, acc);
    @(negedge clk);
`ifdef LANE_STAGE_SKID_EN
    drive(1'b1, 2'b11, 32'h4444_0006, 8'h46, 1'b0, 1'b0, acc);
    @(negedge clk);
`endif
    idle();
    chk("rm_occ_pre", occ, FULL);
    #1;
    rst = 1'b1;
    #1;
    chk("rm_valid", bif.out_valid, 1'b0);
    chk("rm_en", bif.out_lane_en, 2'b00);
    chk("rm_data", bif.out_data, 32'h0);
    chk("rm_side", bif.out_side, 8'h0);
    chk("rm_occ", occ, 2'd0);
    chk("rm_bub", bub, 16'd0);
    chk("rm_bub2", bub2, 4'd0);
    chk("rm_rdy", bif.in_ready, 1'b1);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lane_stage_reg.md
# lane_stage_reg

Parametrised, elastic multi-lane pipeline stage register that succeeds the fixed dual-issue EX/MEM latch. It carries LANES per-lane payloads plus one shared sideband word per issue group between two pipeline stages. It replaces the global stall vector with a valid/ready handshake and an optional skid entry, and adds exception flush, per-lane enables, occupancy and a bubble counter.

## Interface
- LANES, 2, issue lanes per group (1..4)
- DW, 104, payload bits per lane (wd, wreg, wdata, excepttype, delayslot, inst_addr)
- SW, 150, shared sideband bits per group (aluop, mem addr, reg2, cp0, LLbit, hilo, cnt)
- CNT_W, 16, bubble counter width
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  flush request
- flush_cause  in  1  1 = exception flush; 0 = non-exception (ignored by this block)
- in_valid  in  1  upstream group valid
- in_lane_en  in  LANES  per-lane valid within the group
- in_data  in  LANES*DW  lane i at [i*DW +: DW]
- in_side  in  SW  shared sideband
- in_ready  out  1  stage accepts a group this cycle
- out_valid  out  1  group held at output
- out_lane_en  out  LANES  per-lane valid of output group
- out_data  out  LANES*DW  output payloads
- out_side  out  SW  output sideband
- out_ready  in  1  downstream consumes output this cycle
- occupancy  out  2  groups held (0..2)
- bubble_cnt  out  CNT_W  cycles with out_valid=0 and not in reset, saturating

## Operation
- Push = in_valid & in_ready & |in_lane_en; in_valid with in_lane_en=0 is accepted and discarded (no storage).
- Pop = out_valid & out_ready.
- Storage: main entry (drives outputs) and, with skid, one skid entry. Entry = {lane_en, data, side}.
- Invalid output: out_lane_en, out_data, out_side all zero whenever out_valid=0 (NOP bubble convention); lanes with out_lane_en[i]=0 inside a valid group also drive zero data.
- Priority per cycle: rst > exception flush > push/pop.
- Exception flush (flush=1, flush_cause=1): both entries cleared to zero, occupancy→0, any same-cycle push dropped, out_valid=0 next cycle.
- flush=1, flush_cause=0: no effect; normal handshake.
- Order preserved: skid entry moves to main on pop; push goes to main if main empty or popping with skid empty, else to skid.
- Simultaneous push and pop at occupancy 1: main replaced by new group, occupancy stays 1.
- Occupancy 2 with no pop: in_ready=0 next cycle; no overwrite ever.
- bubble_cnt: +1 per cycle out_valid=0, saturates at all-ones, cleared only by rst (not by flush).

## Timing
- Reset (async assert, sync-release by environment): out_valid=0, out_lane_en=0, out_data=0, out_side=0, occupancy=0, bubble_cnt=0, in_ready=1 (skid build) / 1 (no-skid build, as out_valid=0).
- Latency: push in cycle N → out_valid=1 with that group in cycle N+1.
- Throughput: one group per cycle with out_ready held high.
- Skid build: in_ready is a register, in_ready = (occupancy next < 2); deasserts the cycle after main and skid both fill.
- Reset mid-operation: all entries lost immediately, outputs zero without waiting for clk.
- Flush and rst have no effect on bubble_cnt beyond rst clearing it.

## Configuration
- LANE_STAGE_SKID_EN defined: two entries, registered in_ready, occupancy 0..2.
- Not defined: main entry only; in_ready = out_ready | ~out_valid (combinational); occupancy 0..1; all other behaviour identical.

## Test plan
- Reset: assert rst mid-stream with occupancy 2 → all outputs 0, occupancy 0, bubble_cnt 0 asynchronously.
- Streaming: LANES=2, 8 back-to-back groups, out_ready=1 → outputs in order, one cycle late, no bubbles, bubble_cnt unchanged.
- Backpressure (skid): out_ready=0 for 3 cycles while pushing A,B,C → A,B held, in_ready=0 after B, C held off upstream; release → A, B, C in order, none lost or duplicated.
- Exception flush: occupancy 2, push D with flush=1, flush_cause=1 → next cycle out_valid=0, occupancy 0, D dropped; flush_cause=0 same stimulus → D enqueued normally.
- Lane masking: push in_lane_en=2'b10, lane0 data 0xDEAD → out_lane_en=2'b10, lane0 out_data=0; in_lane_en=0 with in_valid=1 → nothing stored.
- Bubble counter: CNT_W=4, idle 20 cycles → bubble_cnt saturates at 15.
